// File: rtl/scope_nch_capture.sv
// Multi-channel oscilloscope capture: circular sample buffer, level/edge trigger, register read/write port.
// Optional SCOPE_DECIM_EN macro enables sample decimation through the DECIM register.
module scope_nch_capture #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic [13:0]              reg_addr,
  input  logic                     reg_wr_en,
  input  logic [31:0]              reg_wdata,
  input  logic                     reg_rd_en,
  output logic [31:0]              reg_rdata,
  output logic                     reg_rvalid,
  output logic                     busy,
  output logic                     irq
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [13:0] A_CTRL   = 14'h0000;
  localparam logic [13:0] A_LEVEL  = 14'h0004;
  localparam logic [13:0] A_POST   = 14'h0008;
  localparam logic [13:0] A_STATUS = 14'h000C;
  localparam logic [13:0] A_CHSEL  = 14'h0010;
  localparam logic [13:0] A_DECIM  = 14'h0014;

  localparam logic [CW-1:0]         ONE_C    = CW'(1);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [3:0]            NUM_CH_L = 4'(NUM_CH);

  logic [1:0]               state_reg;
  logic [1:0]               mode_reg;
  logic [2:0]               tch_reg;
  logic signed [DATA_W-1:0] level_reg;
  logic [31:0]              post_reg;
  logic [2:0]               chsel_reg;
  logic [DEPTH_LOG2-1:0]    wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]    trig_ptr_reg;
  logic [CW-1:0]            fill_reg;
  logic [CW-1:0]            post_cnt_reg;
  logic signed [DATA_W-1:0] prev_reg;
  logic                     has_prev_reg;
  logic                     irq_reg;
  logic                     rvalid_reg;
  logic                     rd_win_reg;
  logic [2:0]               rd_ch_reg;
  logic [31:0]              rd_val_reg;

  logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] ram_q_reg;

  logic signed [DATA_W-1:0] in_ch [8];
  logic signed [DATA_W-1:0] rd_ch [8];

  // Channels above NUM_CH read as zero so an 8-entry select never goes out of range.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_on
        assign in_ch[gi] = sample_data[gi*DATA_W +: DATA_W];
        assign rd_ch[gi] = ram_q_reg[gi*DATA_W +: DATA_W];
      end else begin : g_off
        assign in_ch[gi] = '0;
        assign rd_ch[gi] = '0;
      end
    end
  endgenerate

  logic cfg_open, ctrl_wr, arm_req, abort_req, dec_ok, frame_acc;

  assign cfg_open  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign busy      = !cfg_open;
  assign ctrl_wr   = reg_wr_en && (reg_addr == A_CTRL);
  assign arm_req   = ctrl_wr && reg_wdata[0];
  assign abort_req = ctrl_wr && reg_wdata[1];

`ifdef SCOPE_DECIM_EN
  logic [31:0] decim_reg;
  logic [31:0] dec_cnt_reg;
  assign dec_ok = (dec_cnt_reg == 32'd0);
`else
  assign dec_ok = 1'b1;
`endif

  assign frame_acc = sample_valid && busy && dec_ok;

  // Trigger evaluation on the incoming frame, using configuration as it stood before this edge.
  logic [2:0]               tch_eff;
  logic signed [DATA_W-1:0] cur;
  logic [CW-1:0]            post_eff;
  logic [CW-1:0]            thresh;
  logic                     eligible, rise, fall, hit;

  always_comb begin
    tch_eff = ({1'b0, tch_reg} < NUM_CH_L) ? tch_reg : 3'd0;
    cur     = in_ch[tch_eff];
    if (post_reg == 32'd0)
      post_eff = ONE_C;
    else if (post_reg > 32'(DEPTH))
      post_eff = DEPTH_C;
    else
      post_eff = post_reg[CW-1:0];
    thresh   = DEPTH_C - post_eff;
    eligible = (fill_reg >= thresh);
    rise     = has_prev_reg && (prev_reg < level_reg) && (cur >= level_reg);
    fall     = has_prev_reg && (prev_reg > level_reg) && (cur <= level_reg);
    hit      = 1'b0;
    case (mode_reg)
      2'b00:   hit = 1'b1;
      2'b01:   hit = rise;
      2'b10:   hit = fall;
      default: hit = rise || fall;
    endcase
  end

  logic [10:0]           rd_idx;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [31:0]           status_word;
  logic [31:0]           reg_val;

  assign rd_idx  = reg_addr[12:2];
  assign rd_addr = wr_ptr_reg + DEPTH_LOG2'(rd_idx);

  always_comb begin
    status_word                     = '0;
    status_word[16 +: DEPTH_LOG2]   = trig_ptr_reg;
    status_word[2]                  = (state_reg == ST_DONE);
    status_word[1:0]                = state_reg;
    reg_val = '0;
    case (reg_addr)
      A_CTRL:   reg_val = {25'd0, tch_reg, mode_reg, 2'b00};
      A_LEVEL:  reg_val = 32'(level_reg);
      A_POST:   reg_val = post_reg;
      A_STATUS: reg_val = status_word;
      A_CHSEL:  reg_val = {29'd0, chsel_reg};
`ifdef SCOPE_DECIM_EN
      A_DECIM:  reg_val = decim_reg;
`endif
      default:  reg_val = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (frame_acc)
      mem[wr_ptr_reg] <= sample_data;
    if (reg_rd_en)
      ram_q_reg <= mem[rd_addr];
  end

  logic signed [31:0] win_word;
  assign win_word   = 32'(rd_ch[rd_ch_reg]);
  assign reg_rdata  = rd_win_reg ? win_word : rd_val_reg;
  assign reg_rvalid = rvalid_reg;
  assign irq        = irq_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= '0;
      tch_reg      <= '0;
      level_reg    <= '0;
      post_reg     <= '0;
      chsel_reg    <= '0;
      wr_ptr_reg   <= '0;
      trig_ptr_reg <= '0;
      fill_reg     <= '0;
      post_cnt_reg <= '0;
      prev_reg     <= '0;
      has_prev_reg <= 1'b0;
      irq_reg      <= 1'b0;
      rvalid_reg   <= 1'b0;
      rd_win_reg   <= 1'b0;
      rd_ch_reg    <= '0;
      rd_val_reg   <= '0;
`ifdef SCOPE_DECIM_EN
      decim_reg    <= '0;
      dec_cnt_reg  <= '0;
`endif
    end else begin
      irq_reg    <= 1'b0;
      rvalid_reg <= reg_rd_en;
      if (reg_rd_en) begin
        rd_win_reg <= reg_addr[13] && (state_reg == ST_DONE) && ({1'b0, chsel_reg} < NUM_CH_L);
        rd_ch_reg  <= chsel_reg;
        rd_val_reg <= reg_val;
      end

      if (frame_acc) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
        if (fill_reg != DEPTH_C)
          fill_reg <= fill_reg + ONE_C;
        prev_reg     <= cur;
        has_prev_reg <= 1'b1;
        if (state_reg == ST_ARMED) begin
          if (eligible && hit) begin
            trig_ptr_reg <= wr_ptr_reg;
            post_cnt_reg <= post_eff - ONE_C;
            state_reg    <= ST_POST;
          end
        end else if (post_cnt_reg == '0) begin
          state_reg <= ST_DONE;
          irq_reg   <= 1'b1;
        end else begin
          post_cnt_reg <= post_cnt_reg - ONE_C;
        end
      end

`ifdef SCOPE_DECIM_EN
      if (sample_valid && busy)
        dec_cnt_reg <= (dec_cnt_reg == decim_reg) ? 32'd0 : dec_cnt_reg + 32'd1;
`endif

      if (cfg_open) begin
        if (ctrl_wr) begin
          mode_reg <= reg_wdata[3:2];
          tch_reg  <= reg_wdata[6:4];
        end
        if (reg_wr_en && reg_addr == A_LEVEL) level_reg <= reg_wdata[DATA_W-1:0];
        if (reg_wr_en && reg_addr == A_POST)  post_reg  <= reg_wdata;
        if (reg_wr_en && reg_addr == A_CHSEL) chsel_reg <= reg_wdata[2:0];
`ifdef SCOPE_DECIM_EN
        if (reg_wr_en && reg_addr == A_DECIM) decim_reg <= reg_wdata;
`endif
      end

      if (arm_req && cfg_open) begin
        wr_ptr_reg   <= '0;
        fill_reg     <= '0;
        has_prev_reg <= 1'b0;
        state_reg    <= ST_ARMED;
`ifdef SCOPE_DECIM_EN
        dec_cnt_reg  <= '0;
`endif
      end

      // Abort overrides everything else, including a completion landing on the same edge.
      if (abort_req) begin
        state_reg <= ST_IDLE;
        irq_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scope_nch_capture.sv
// Bench for scope_nch_capture: directed steps with random sample data, checked against a
// frame-index level model of capture, trigger and window readout.
module tb_scope_nch_capture;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 16;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_data = '0;
  logic [13:0] reg_addr = '0;
  logic        reg_wr_en = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic        reg_rd_en = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        busy;
  logic        irq;

  always #5 tb_ACLK = ~tb_ACLK;

  scope_nch_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .sample_valid(sample_valid), .sample_data(sample_data),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .busy(busy), .irq(irq)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: everything is expressed as frame indices counted since ARM.
  int          m_state, m_level, m_count, m_trig_idx, m_prev, m_ptr, m_trig_ptr;
  logic [1:0]  m_mode;
  logic [2:0]  m_tch, m_chsel;
  logic [31:0] m_post, m_decim;
  longint      m_sv;
  logic [47:0] m_mem [DEPTH];
  bit          m_memv [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_level = 0; m_count = 0; m_trig_idx = 0; m_prev = 0; m_ptr = 0;
    m_trig_ptr = 0; m_mode = 0; m_tch = 0; m_chsel = 0; m_post = 0; m_decim = 0; m_sv = 0;
  endfunction

  function automatic int ch_val(input logic [47:0] f, input int k);
    logic [15:0] w;
    w = f[k*16 +: 16];
    return int'($signed(w));
  endfunction

  function automatic int post_eff();
    if (m_post == 0) return 1;
    if (m_post > DEPTH) return DEPTH;
    return int'(m_post);
  endfunction

  function automatic bit model_frame(input logic [47:0] f);
    bit ir;
    bit hit;
    int cur;
    ir = 0;
    if (!(m_state == 1 || m_state == 2)) return 0;
`ifdef SCOPE_DECIM_EN
    begin
      bit acc;
      acc = (m_sv % (longint'(m_decim) + 1)) == 0;
      m_sv++;
      if (!acc) return 0;
    end
`endif
    cur = ch_val(f, (m_tch < NUM_CH) ? int'(m_tch) : 0);
    m_mem[m_ptr] = f;
    m_memv[m_ptr] = 1;
    if (m_state == 1) begin
      hit = 0;
      if (m_count >= DEPTH - post_eff()) begin
        case (m_mode)
          2'd0: hit = 1;
          2'd1: hit = (m_count > 0) && m_prev < m_level && cur >= m_level;
          2'd2: hit = (m_count > 0) && m_prev > m_level && cur <= m_level;
          default: hit = (m_count > 0) && ((m_prev < m_level && cur >= m_level) ||
                                           (m_prev > m_level && cur <= m_level));
        endcase
      end
      if (hit) begin
        m_state = 2; m_trig_idx = m_count; m_trig_ptr = m_ptr;
      end
    end else if (m_count == m_trig_idx + post_eff()) begin
      m_state = 3; ir = 1;
    end
    m_prev = cur;
    m_ptr = (m_ptr + 1) % DEPTH;
    m_count++;
    return ir;
  endfunction

  function automatic void model_write(input logic [13:0] a, input logic [31:0] d);
    bit bsy;
    bsy = (m_state == 1 || m_state == 2);
    case (a)
      14'h0000: begin
        if (!bsy) begin m_mode = d[3:2]; m_tch = d[6:4]; end
        if (d[1]) m_state = 0;
        else if (d[0] && !bsy) begin m_state = 1; m_count = 0; m_ptr = 0; m_sv = 0; end
      end
      14'h0004: if (!bsy) m_level = int'($signed(d[15:0]));
      14'h0008: if (!bsy) m_post = d;
      14'h0010: if (!bsy) m_chsel = d[2:0];
      14'h0014: begin
`ifdef SCOPE_DECIM_EN
        if (!bsy) m_decim = d;
`endif
      end
      default: ;
    endcase
  endfunction

  function automatic void model_read(input logic [13:0] a, output logic [31:0] e, output bit known);
    int idx;
    known = 1; e = '0;
    if (a[13]) begin
      if (m_state == 3) begin
        idx = (m_ptr + int'(a[12:2])) % DEPTH;
        if (!m_memv[idx]) known = 0;
        else if (m_chsel < NUM_CH) e = 32'(ch_val(m_mem[idx], int'(m_chsel)));
      end
    end else begin
      case (a)
        14'h0000: e = {25'd0, m_tch, m_mode, 2'b00};
        14'h0004: e = 32'(m_level);
        14'h0008: e = m_post;
        14'h000C: begin
          e = 32'(m_trig_ptr) << 16;
          if (m_state == 3) e[2] = 1'b1;
          e[1:0] = 2'(m_state);
        end
        14'h0010: e = {29'd0, m_chsel};
`ifdef SCOPE_DECIM_EN
        14'h0014: e = m_decim;
`endif
        default: e = '0;
      endcase
    end
  endfunction

  function automatic logic [15:0] rnd(input int lo, input int hi);
    return 16'(int'($urandom_range(0, hi - lo)) + lo);
  endfunction

  function automatic logic [47:0] mk(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge tb_ACLK);
    reg_addr = a; reg_wdata = d; reg_wr_en = 1'b1;
    model_write(a, d);
    @(negedge tb_ACLK);
    reg_wr_en = 1'b0;
    $display("[TB] wr addr=0x%04h data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [13:0] a);
    logic [31:0] e;
    bit k;
    model_read(a, e, k);
    @(negedge tb_ACLK);
    reg_addr = a; reg_rd_en = 1'b1;
    @(negedge tb_ACLK);
    reg_rd_en = 1'b0;
    check($sformatf("rvalid@%04h", a), {31'd0, reg_rvalid}, 32'd1);
    if (k) check($sformatf("rdata@%04h", a), reg_rdata, e);
    $display("[TB] rd addr=0x%04h data=0x%08h model=0x%08h known=%0d", a, reg_rdata, e, k);
    @(negedge tb_ACLK);
    check($sformatf("rvalid_drop@%04h", a), {31'd0, reg_rvalid}, 32'd0);
  endtask

  task automatic frame(input logic [47:0] f);
    bit ei;
    logic [31:0] eb;
    ei = model_frame(f);
    eb = (m_state == 1 || m_state == 2) ? 32'd1 : 32'd0;
    @(negedge tb_ACLK);
    sample_valid = 1'b1; sample_data = f;
    @(negedge tb_ACLK);
    sample_valid = 1'b0;
    check("irq", {31'd0, irq}, {31'd0, ei});
    check("busy", {31'd0, busy}, eb);
    $display("[TB] frame ch0=%0d ch1=%0d ch2=%0d irq=%0b busy=%0b", ch_val(f, 0), ch_val(f, 1), ch_val(f, 2), irq, busy);
  endtask

  task automatic run_frames(input int kind, input int limit, input bit until_done);
    logic [47:0] f;
    for (int n = 0; n < limit; n++) begin
      if (until_done && m_state == 3) break;
      case (kind)
        0:       f = mk(16'(n), rnd(-8, 8), rnd(-8, 8));
        2:       f = mk(rnd(-8, 8), rnd(50, 150), rnd(-8, 8));
        default: f = mk(rnd(-8, 8), rnd(-8, 8), rnd(-8, 8));
      endcase
      frame(f);
    end
  endtask

  task automatic dump_window(input logic [2:0] cs);
    wr(14'h0010, {29'd0, cs});
    for (int i = 0; i < DEPTH; i++) rd(14'h2000 + 14'(i * 4));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ctl;
    int post_tab [5] = '{0, 100, 1, 7, 16};
    for (int i = 0; i < DEPTH; i++) m_memv[i] = 0;
    model_reset();

    // Outputs while held in reset
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    @(negedge tb_ACLK);
    ARESETN = 1'b1;
    rd(14'h0000); rd(14'h0004); rd(14'h0008); rd(14'h000C);
    rd(14'h0010); rd(14'h0014); rd(14'h0018); rd(14'h2000);

    // Immediate trigger, full post window
    wr(14'h0008, 32'd16);
    wr(14'h0000, 32'h1);
    rd(14'h000C);
    run_frames(0, 40, 1);
    rd(14'h000C);
    dump_window(3'd0);
    wr(14'h0010, 32'd2);
    rd(14'h2014); rd(14'h203C);
    wr(14'h0014, 32'd2);
    rd(14'h0014);

    // Rising edge on ch1; config writes and re-ARM ignored while armed
    wr(14'h0004, 32'd100);
    wr(14'h0008, 32'd4);
    wr(14'h0000, 32'h15);
    run_frames(2, 3, 0);
    wr(14'h0004, 32'd7);
    wr(14'h0000, 32'h1);
    wr(14'h0008, 32'd9);
    rd(14'h0004); rd(14'h0008); rd(14'h000C);
    run_frames(2, 200, 1);
    rd(14'h000C);
    dump_window(3'd1);

    // Falling edge on ch2 at level 0: first frame after ARM must not use stale history
    wr(14'h0004, 32'd0);
    wr(14'h0008, 32'd16);
    wr(14'h0000, 32'h29);
    frame(mk(16'd0, 16'd0, 16'hFFFB));
    frame(mk(16'd0, 16'd0, 16'd3));
    rd(14'h000C);
    frame(mk(16'd0, 16'd0, 16'hFFFB));
    rd(14'h000C);
    run_frames(1, 40, 1);
    rd(14'h000C);
    dump_window(3'd2);

    // Abort during POST
    wr(14'h0008, 32'd8);
    wr(14'h0000, 32'h1);
    for (int n = 0; n < 40 && m_state != 2; n++) frame(mk(rnd(-8, 8), rnd(-8, 8), rnd(-8, 8)));
    run_frames(1, 3, 0);
    wr(14'h0000, 32'h2);
    rd(14'h000C);
    run_frames(1, 12, 0);
    wr(14'h0004, 32'd7);
    rd(14'h0004);
    rd(14'h2000); rd(14'h203C);
    wr(14'h0000, 32'h3);
    rd(14'h000C);

    // Randomised captures: POST clamping, out-of-range trigger channel, all modes
    for (int it = 0; it < 5; it++) begin
      ctl = ($urandom % 8) << 4 | ($urandom % 4) << 2 | 32'h1;
      wr(14'h0004, 32'(int'($urandom_range(0, 6)) - 3));
      wr(14'h0008, 32'(post_tab[it]));
      wr(14'h0000, ctl);
      run_frames(1, 120, 1);
      if (m_state != 3) wr(14'h0000, 32'h2);
      rd(14'h000C);
      dump_window(3'($urandom % 3));
    end

    // Asynchronous reset on the edge that completes the capture
    wr(14'h0008, 32'd2);
    wr(14'h0000, 32'h1);
    rd(14'h0008);
    run_frames(0, 16, 0);
    rd(14'h000C);
    void'(model_frame(mk(16'd16, 16'd0, 16'd0)));
    @(negedge tb_ACLK);
    sample_valid = 1'b1; sample_data = mk(16'd16, 16'd0, 16'd0);
    @(posedge tb_ACLK);
    #1;
    check("irq_pre_reset", {31'd0, irq}, 32'd1);
    #1;
    ARESETN = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    check("arst_rdata", reg_rdata, 32'd0);
    $display("[TB] async reset asserted during completion");
    model_reset();
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    ARESETN = 1'b1;
    rd(14'h000C); rd(14'h0008); rd(14'h0004); rd(14'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
